// File: rtl/mem_arb_pkg.sv
// Shared definitions for the round-robin memory arbiter: FSM encodings,
// PID width sizing and tag pack/unpack helpers.
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;

    function automatic int pid_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Tag layout is {pid, seq}; seq occupies the low seq_bits.
    function automatic logic [31:0] tag_pack(input int pid, input int seq, input int seq_bits);
        return 32'(pid << seq_bits) | 32'(seq);
    endfunction

    function automatic int tag_pid(input logic [31:0] tag, input int seq_bits);
        return int'(tag >> seq_bits);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first eligible client at or after ptr,
// returned both one-hot and as an index.
module rr_priority_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_any
);

    int p;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        p         = 0;
        for (int i = 0; i < N; i++) begin
            p = (int'(ptr) + i) % N;
            if (!grant_any && eligible[p]) begin
                grant_any = 1'b1;
                grant[p]  = 1'b1;
                grant_idx = IW'(p);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter of NUM_PORTS cache clients onto one tagged memory channel,
// with write-data forwarding, per-client read limits and tag-routed responses.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int MEM_ADDR_BITS   = 28,
    parameter int MEM_TAG_BITS    = 5,
    parameter int MEM_DATA_BITS   = 128,
    parameter int DATA_BEATS      = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 cl_req_valid,
    output logic [NUM_PORTS-1:0]                 cl_req_ready,
    input  logic [NUM_PORTS-1:0]                 cl_req_rw,
    input  logic [NUM_PORTS*MEM_ADDR_BITS-1:0]   cl_req_addr,
    input  logic [NUM_PORTS-1:0]                 cl_req_data_valid,
    output logic [NUM_PORTS-1:0]                 cl_req_data_ready,
    input  logic [NUM_PORTS*MEM_DATA_BITS-1:0]   cl_req_data_bits,
    input  logic [NUM_PORTS*MEM_DATA_BITS/8-1:0] cl_req_data_mask,
    output logic [NUM_PORTS-1:0]                 cl_resp_valid,
    output logic                                 mem_req_valid,
    input  logic                                 mem_req_ready,
    output logic                                 mem_req_rw,
    output logic [MEM_ADDR_BITS-1:0]             mem_req_addr,
    output logic [MEM_TAG_BITS-1:0]              mem_req_tag,
    output logic                                 mem_req_data_valid,
    input  logic                                 mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]             mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0]           mem_req_data_mask,
    input  logic                                 mem_resp_valid,
    input  logic [MEM_TAG_BITS-1:0]              mem_resp_tag,
    output logic                                 err_bad_tag
);

    localparam int PID_BITS  = pid_bits(NUM_PORTS);
    localparam int SEQ_BITS  = MEM_TAG_BITS - PID_BITS;
    localparam int MASK_BITS = MEM_DATA_BITS / 8;
    localparam int BEAT_BITS = $clog2(DATA_BEATS + 1);
    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    logic [1:0]                          state;
    logic [PID_BITS-1:0]                 rr_ptr, pid_q;
    logic                                rw_q;
    logic [MEM_ADDR_BITS-1:0]            addr_q;
    logic [MEM_TAG_BITS-1:0]             tag_q;
    logic [BEAT_BITS-1:0]                beat_cnt;
    logic [NUM_PORTS-1:0][SEQ_BITS-1:0]  seq;
    logic [NUM_PORTS-1:0][3:0]           outst;
    logic [NUM_PORTS-1:0]                eligible, grant, rd_issue;
    logic [PID_BITS-1:0]                 win_idx;
    logic                                win_any, data_hs, resp_in_range;
    logic [PID_BITS-1:0]                 resp_pid;

    // A client at its read limit may still be granted for a write.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++)
            eligible[p] = cl_req_valid[p] && (cl_req_rw[p] || outst[p] < MAX_OUT);
    end

    rr_priority_picker #(.N(NUM_PORTS), .IW(PID_BITS)) u_picker (
        .eligible  (eligible),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    assign resp_pid      = PID_BITS'(tag_pid(32'(mem_resp_tag), SEQ_BITS));
    assign resp_in_range = tag_pid(32'(mem_resp_tag), SEQ_BITS) < NUM_PORTS;

    // Combinational outputs are gated by reset so they drop the instant it asserts.
    assign cl_req_ready       = (reset && state == IDLE && win_any) ? grant : '0;
    assign mem_req_valid      = (state == REQ);
    assign mem_req_rw         = rw_q;
    assign mem_req_addr       = addr_q;
    assign mem_req_tag        = tag_q;
    assign mem_req_data_valid = (state == WDATA) && cl_req_data_valid[pid_q];
    assign mem_req_data_bits  = cl_req_data_bits[pid_q*MEM_DATA_BITS +: MEM_DATA_BITS];
    assign mem_req_data_mask  = cl_req_data_mask[pid_q*MASK_BITS +: MASK_BITS];
    assign data_hs            = mem_req_data_valid && mem_req_data_ready;

    always_comb begin
        cl_req_data_ready = '0;
        if (state == WDATA)
            cl_req_data_ready[pid_q] = mem_req_data_ready;
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            cl_resp_valid[p] = reset && mem_resp_valid && resp_in_range && (32'(resp_pid) == p);
            rd_issue[p]      = (state == REQ) && mem_req_ready && !rw_q && (32'(pid_q) == p);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            pid_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            tag_q    <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (win_any) begin
                    pid_q  <= win_idx;
                    rw_q   <= cl_req_rw[win_idx];
                    addr_q <= cl_req_addr[win_idx*MEM_ADDR_BITS +: MEM_ADDR_BITS];
                    tag_q  <= MEM_TAG_BITS'(tag_pack(int'(win_idx), int'(seq[win_idx]), SEQ_BITS));
                    state  <= REQ;
                end
                REQ: if (mem_req_ready) begin
                    rr_ptr   <= (32'(pid_q) == NUM_PORTS - 1) ? '0 : pid_q + 1'b1;
                    state    <= rw_q ? WDATA : IDLE;
                    beat_cnt <= '0;
                end
                WDATA: if (data_hs) begin
                    if (beat_cnt == BEAT_BITS'(DATA_BEATS - 1)) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // An issue and a response for the same client in one cycle cancel out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seq         <= '0;
            outst       <= '0;
            err_bad_tag <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (rd_issue[p])
                    seq[p] <= seq[p] + 1'b1;
                if (rd_issue[p] && !cl_resp_valid[p])
                    outst[p] <= outst[p] + 1'b1;
                else if (!rd_issue[p] && cl_resp_valid[p] && outst[p] != 4'd0)
                    outst[p] <= outst[p] - 1'b1;
            end
            if (mem_resp_valid && !resp_in_range)
                err_bad_tag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_mem_rr_arbiter;

    localparam int N = 3, A = 16, T = 5, D = 32, M = D / 8, BEATS = 4, MAXO = 2;
    localparam int SB = 3;  // seq bits: T minus 2 pid bits for three clients

    logic clk = 1'b0, reset = 1'b0;
    logic [N-1:0]   cl_req_valid, cl_req_ready, cl_req_rw, cl_req_data_valid, cl_req_data_ready, cl_resp_valid;
    logic [N*A-1:0] cl_req_addr;
    logic [N*D-1:0] cl_req_data_bits;
    logic [N*M-1:0] cl_req_data_mask;
    logic           mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
    logic [A-1:0]   mem_req_addr;
    logic [T-1:0]   mem_req_tag, mem_resp_tag;
    logic [D-1:0]   mem_req_data_bits;
    logic [M-1:0]   mem_req_data_mask;
    logic           mem_resp_valid, err_bad_tag;

    mem_rr_arbiter #(.NUM_PORTS(N), .MEM_ADDR_BITS(A), .MEM_TAG_BITS(T), .MEM_DATA_BITS(D),
                     .DATA_BEATS(BEATS), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset(reset),
        .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready), .cl_req_rw(cl_req_rw),
        .cl_req_addr(cl_req_addr), .cl_req_data_valid(cl_req_data_valid),
        .cl_req_data_ready(cl_req_data_ready), .cl_req_data_bits(cl_req_data_bits),
        .cl_req_data_mask(cl_req_data_mask), .cl_resp_valid(cl_resp_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .err_bad_tag(err_bad_tag)
    );

    always #5 clk = ~clk;

    int vecs = 0, errs = 0;
    // Reference model: one transaction in flight, rr pointer, per-client seq/outstanding.
    int m_ptr, m_seq[N], m_outst[N];
    bit m_err, t_busy, t_issued, t_rw;
    int t_pid, t_beats;
    logic [A-1:0] t_addr;
    logic [T-1:0] t_tag;
    int rd_q[$];
    logic [T-1:0] tag_log[$];
    int iss_cnt[N];
    int beat_cnt;
    logic [N-1:0] hold_mask;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_err = 0; t_busy = 0; t_issued = 0; t_beats = 0;
        for (int p = 0; p < N; p++) begin m_seq[p] = 0; m_outst[p] = 0; iss_cnt[p] = 0; end
        rd_q.delete(); tag_log.delete(); beat_cnt = 0;
    endtask

    task automatic clear_inputs();
        cl_req_valid = '0; cl_req_rw = '0; cl_req_addr = '0; cl_req_data_valid = '0;
        cl_req_data_bits = '0; cl_req_data_mask = '0; mem_req_ready = 1'b0;
        mem_req_data_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0; hold_mask = '0;
    endtask

    task automatic rq_remove(input int tag);
        foreach (rd_q[i]) if (rd_q[i] == tag) begin rd_q.delete(i); return; end
    endtask

    // Called at posedge+1; releases reset at the following posedge+1.
    task automatic do_reset();
        reset = 1'b0; clear_inputs();
        @(posedge clk); #1;
        reset = 1'b1; model_reset();
    endtask

    // One clock: compare at negedge against the model, then advance the model.
    task automatic cyc();
        logic [N-1:0] e_rdy, e_drdy, e_resp, elig, acc;
        bit any, e_mv, e_dv;
        int win, rp, issue;
        @(negedge clk);
        e_rdy = '0; e_drdy = '0; e_resp = '0; any = 0; win = 0; issue = -1;
        for (int p = 0; p < N; p++) elig[p] = cl_req_valid[p] && (cl_req_rw[p] || m_outst[p] < MAXO);
        if (!t_busy)
            for (int i = 0; i < N; i++)
                if (!any && elig[(m_ptr + i) % N]) begin any = 1; win = (m_ptr + i) % N; end
        if (any) e_rdy[win] = 1'b1;
        e_mv = t_busy && !t_issued;
        e_dv = t_busy && t_issued && cl_req_data_valid[t_pid];
        if (t_busy && t_issued) e_drdy[t_pid] = mem_req_data_ready;
        rp = int'(mem_resp_tag) >> SB;
        if (mem_resp_valid && rp < N) e_resp[rp] = 1'b1;

        chk("cl_req_ready", cl_req_ready, e_rdy);
        chk("mem_req_valid", mem_req_valid, e_mv);
        if (e_mv) begin
            chk("mem_req_rw", mem_req_rw, t_rw);
            chk("mem_req_addr", mem_req_addr, t_addr);
            chk("mem_req_tag", mem_req_tag, t_tag);
        end
        chk("mem_req_data_valid", mem_req_data_valid, e_dv);
        if (e_dv) begin
            chk("mem_req_data_bits", mem_req_data_bits, cl_req_data_bits[t_pid*D +: D]);
            chk("mem_req_data_mask", mem_req_data_mask, cl_req_data_mask[t_pid*M +: M]);
        end
        chk("cl_req_data_ready", cl_req_data_ready, e_drdy);
        chk("cl_resp_valid", cl_resp_valid, e_resp);
        chk("err_bad_tag", err_bad_tag, m_err);

        if (mem_req_valid && mem_req_ready) begin
            tag_log.push_back(mem_req_tag);
            if (!mem_req_rw) iss_cnt[int'(mem_req_tag) >> SB]++;
        end
        if (mem_req_data_valid && mem_req_data_ready) beat_cnt++;

        if (!t_busy) begin
            if (any) begin
                t_busy = 1; t_issued = 0; t_pid = win; t_rw = cl_req_rw[win];
                t_addr = cl_req_addr[win*A +: A]; t_tag = T'((win << SB) | m_seq[win]);
            end
        end else if (!t_issued) begin
            if (mem_req_ready) begin
                m_ptr = (t_pid + 1) % N;
                if (!t_rw) begin
                    issue = t_pid; m_seq[t_pid] = (m_seq[t_pid] + 1) % (1 << SB);
                    rd_q.push_back(int'(t_tag)); t_busy = 0;
                end else begin
                    t_issued = 1; t_beats = 0;
                end
            end
        end else if (cl_req_data_valid[t_pid] && mem_req_data_ready) begin
            t_beats++;
            if (t_beats == BEATS) t_busy = 0;
        end
        for (int p = 0; p < N; p++) begin
            if (issue == p && !e_resp[p]) m_outst[p]++;
            else if (issue != p && e_resp[p] && m_outst[p] > 0) m_outst[p]--;
        end
        if (mem_resp_valid && rp >= N) m_err = 1;
        acc = e_rdy & cl_req_valid;

        @(posedge clk); #1;
        for (int p = 0; p < N; p++)
            if (acc[p]) begin
                if (hold_mask[p]) cl_req_addr[p*A +: A] = A'($urandom);
                else cl_req_valid[p] = 1'b0;
            end
    endtask

    task automatic drive_rand();
        for (int p = 0; p < N; p++)
            if (!cl_req_valid[p]) begin
                cl_req_valid[p] = ($urandom_range(0, 99) < 60);
                cl_req_rw[p] = ($urandom_range(0, 99) < 30);
                cl_req_addr[p*A +: A] = A'($urandom);
            end
        cl_req_data_valid = N'($urandom);
        cl_req_data_bits = {$urandom, $urandom, $urandom};
        cl_req_data_mask = N*M'($urandom);
        mem_req_ready = ($urandom_range(0, 3) != 0);
        mem_req_data_ready = 1'($urandom);
        mem_resp_valid = 1'b0;
        if (rd_q.size() > 0 && $urandom_range(0, 2) == 0) begin
            int k;
            k = $urandom_range(0, rd_q.size() - 1);
            mem_resp_tag = T'(rd_q[k]); rd_q.delete(k); mem_resp_valid = 1'b1;
        end
    endtask

    initial begin
        clear_inputs(); model_reset();
        // Under reset: every valid/ready output low despite active inputs.
        cl_req_valid = 3'b111; mem_req_data_ready = 1'b1; mem_resp_valid = 1'b1;
        #2;
        chk("rst_cl_req_ready", cl_req_ready, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_data_valid", mem_req_data_valid, 0);
        chk("rst_cl_data_ready", cl_req_data_ready, 0);
        chk("rst_cl_resp_valid", cl_resp_valid, 0);
        chk("rst_err_bad_tag", err_bad_tag, 0);
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b1;

        // Clients 0 and 1 read at reset release.
        cl_req_valid = 3'b011; cl_req_addr = {16'h0, 16'h1111, 16'h0000}; mem_req_ready = 1'b1;
        repeat (4) cyc();
        chk("first_tag", tag_log[0], 5'h00);
        chk("second_tag", tag_log[1], 5'h08);
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h08; rq_remove(8);
        #1 chk("resp_route", cl_resp_valid, 3'b010);
        cyc();
        mem_resp_valid = 1'b0;

        // All clients hold reads; first request stalls 5 cycles.
        do_reset();
        cl_req_valid = 3'b111; hold_mask = 3'b111; cl_req_addr = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        repeat (6) cyc();
        mem_req_ready = 1'b1;
        repeat (8) cyc();
        chk("rr_count", tag_log.size(), 4);
        chk("rr_g0", tag_log[0], 5'h00);
        chk("rr_g1", tag_log[1], 5'h08);
        chk("rr_g2", tag_log[2], 5'h10);
        chk("rr_g3", tag_log[3], 5'h01);

        // Client 0 capped at MAX_OUTSTANDING reads while client 1 is still served.
        do_reset();
        cl_req_valid = 3'b011; hold_mask = 3'b001; mem_req_ready = 1'b1;
        repeat (10) cyc();
        chk("cap_c0_issued", iss_cnt[0], 2);
        chk("cap_c1_issued", iss_cnt[1], 1);
        chk("cap_c0_masked", cl_req_ready, 0);
        mem_resp_valid = 1'b1; mem_resp_tag = 5'h00; rq_remove(0);
        cyc();
        mem_resp_valid = 1'b0;
        repeat (3) cyc();
        chk("cap_c0_resumed", iss_cnt[0], 3);

        // Client 1 write, data_ready toggling 1010...
        do_reset();
        cl_req_valid = 3'b010; cl_req_rw = 3'b010; cl_req_data_valid = 3'b011; mem_req_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            mem_req_data_ready = (k % 2 == 0);
            cl_req_data_bits = {$urandom, $urandom, $urandom};
            cl_req_data_mask = 12'($urandom);
            cyc();
        end
        chk("write_beats", beat_cnt, 4);

        // Bad pid, then a response to a client with nothing outstanding.
        cl_req_data_valid = '0; cl_req_rw = '0;
        for (int p = 0; p < N; p++) iss_cnt[p] = 0;
        mem_resp_valid = 1'b1; mem_resp_tag = 5'b11000;
        #1 chk("bad_tag_no_resp", cl_resp_valid, 0);
        cyc();
        mem_resp_tag = 5'h10;
        cyc();
        mem_resp_valid = 1'b0;
        chk("err_sticky", err_bad_tag, 1);
        cl_req_valid = 3'b100; hold_mask = 3'b100;
        repeat (6) cyc();
        chk("sat_c2_issued", iss_cnt[2], 2);

        // Reset lands during the second write beat.
        cl_req_valid = 3'b001; cl_req_rw = 3'b001; hold_mask = '0;
        cl_req_data_valid = 3'b001; mem_req_data_ready = 1'b1;
        repeat (3) cyc();
        #2 chk("wdata_live", mem_req_data_valid, 1);
        cl_req_valid = 3'b111; mem_resp_valid = 1'b1; mem_resp_tag = 5'h00;
        reset = 1'b0;
        #1;
        chk("midrst_cl_req_ready", cl_req_ready, 0);
        chk("midrst_mem_req_valid", mem_req_valid, 0);
        chk("midrst_data_valid", mem_req_data_valid, 0);
        chk("midrst_cl_data_ready", cl_req_data_ready, 0);
        chk("midrst_cl_resp_valid", cl_resp_valid, 0);
        chk("midrst_err_bad_tag", err_bad_tag, 0);
        clear_inputs();
        @(posedge clk); #1;
        reset = 1'b1; model_reset();
        cl_req_valid = 3'b111; hold_mask = 3'b111; mem_req_ready = 1'b1;
        repeat (2) cyc();
        chk("post_rst_tag", tag_log[0], 5'h00);
        repeat (4) cyc();

        // Random traffic.
        hold_mask = '0;
        cl_req_valid = '0;
        repeat (500) begin
            drive_rand();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
